// File: rtl/sync_pkg.sv
// Shared limits and helpers for input synchronizer/filter blocks.
// The UART receiver imports this package as well.
package sync_pkg;

    localparam int CHANNELS_MIN   = 1;
    localparam int CHANNELS_MAX   = 32;
    localparam int STAGES_MIN     = 2;
    localparam int STAGES_MAX     = 4;
    localparam int FILTER_LEN_MAX = 255;

    // Width of a counter able to hold 0..filter_len. Never less than 1 bit.
    function automatic int cnt_width(input int filter_len);
        int w;
        w = $clog2(filter_len + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_filter_channel.sv
// One channel: a metastability sync chain, then a tick-qualified persistence
// filter and a registered edge detector.
module sync_filter_channel
    import sync_pkg::*;
#(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b1,
    parameter int   FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic async_in,
    output logic data_out,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(FILTER_LEN);

    logic [STAGES-1:0] sync_q;
    logic              sync;
    logic              load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= {STAGES{RESET_VALUE}};
        else       sync_q <= {sync_q[STAGES-2:0], async_in};
    end

    assign sync = sync_q[STAGES-1];

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            logic unused_tick;
            assign unused_tick = sample_tick;
            assign load        = (sync != data_out);
        end else begin : g_filter
            localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Count ticks on which the synced level disagrees with the output;
            // any agreeing cycle restarts the run.
            always_comb begin
                load  = 1'b0;
                cnt_d = cnt_q;
                if (sync == data_out) begin
                    cnt_d = '0;
                end else if (sample_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        load  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) cnt_q <= '0;
                else       cnt_q <= cnt_d;
            end
        end
    endgenerate

    // Pulses register alongside data_out so they line up with the new level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RESET_VALUE;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            rise <= load &  sync;
            fall <= load & ~sync;
            if (load) data_out <= sync;
        end
    end

endmodule

// File: rtl/sync_filter_bank.sv
// Bank of independent synchronizer/glitch-filter channels sharing clk, reset
// and the filter sample tick.
module sync_filter_bank
    import sync_pkg::*;
#(
    parameter int                  CHANNELS    = 1,
    parameter int                  STAGES      = 2,
    parameter logic [CHANNELS-1:0] RESET_VALUE = '1,
    parameter int                  FILTER_LEN  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic [CHANNELS-1:0] async_in,
    output logic [CHANNELS-1:0] data_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    generate
        if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
            STAGES < STAGES_MIN || STAGES > STAGES_MAX ||
            FILTER_LEN < 0 || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_params
            $error("sync_filter_bank: parameter out of range");
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            sync_filter_channel #(
                .STAGES      (STAGES),
                .RESET_VALUE (RESET_VALUE[i]),
                .FILTER_LEN  (FILTER_LEN)
            ) u_ch (
                .clk         (clk),
                .reset       (reset),
                .sample_tick (sample_tick),
                .async_in    (async_in[i]),
                .data_out    (data_out[i]),
                .rise        (rise[i]),
                .fall        (fall[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sync_filter_bank.sv
// Three bank configurations driven side by side and compared every cycle
// against a level/run-length reference model, plus directed scenarios.
module tb_sync_filter_bank;

    localparam int STG [3] = '{2, 2, 3};
    localparam int FLN [3] = '{0, 3, 3};
    localparam int RVV [3] = '{1, 1, 10};
    localparam int NCH [3] = '{1, 1, 4};

    logic       clk;
    logic [2:0] rst;
    logic [2:0] tick;
    logic       in0, in1;
    logic [3:0] in2;
    logic       out0, rise0, fall0;
    logic       out1, rise1, fall1;
    logic [3:0] out2, rise2, fall2;

    int n_chk, n_fail;

    int m_pipe [3][4];
    int m_cnt  [3][4];
    int m_out  [3];
    int m_rise [3];
    int m_fall [3];

    sync_filter_bank #(.CHANNELS(1), .STAGES(2), .FILTER_LEN(0)) u_d0 (
        .clk(clk), .reset(rst[0]), .sample_tick(tick[0]), .async_in(in0),
        .data_out(out0), .rise(rise0), .fall(fall0));

    sync_filter_bank #(.CHANNELS(1), .STAGES(2), .FILTER_LEN(3)) u_d1 (
        .clk(clk), .reset(rst[1]), .sample_tick(tick[1]), .async_in(in1),
        .data_out(out1), .rise(rise1), .fall(fall1));

    sync_filter_bank #(.CHANNELS(4), .STAGES(3), .RESET_VALUE(4'b1010), .FILTER_LEN(3)) u_d2 (
        .clk(clk), .reset(rst[2]), .sample_tick(tick[2]), .async_in(in2),
        .data_out(out2), .rise(rise2), .fall(fall2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        for (int s = 0; s < 4; s++) begin
            m_pipe[d][s] = RVV[d];
            m_cnt[d][s]  = 0;
        end
        m_out[d]  = RVV[d];
        m_rise[d] = 0;
        m_fall[d] = 0;
    endtask

    function automatic int in_of(input int d);
        if (d == 0) return int'(in0);
        if (d == 1) return int'(in1);
        return int'(in2);
    endfunction

    // Output flips once a channel has disagreed with its synced level on
    // FILTER_LEN sample ticks in a row (immediately when FILTER_LEN is 0).
    task automatic model_edge(input int d);
        int sync, nxt, s_lvl, o_lvl;
        if (rst[d]) begin
            model_reset(d);
            return;
        end
        sync = m_pipe[d][STG[d]-1];
        nxt  = m_out[d];
        m_rise[d] = 0;
        m_fall[d] = 0;
        for (int c = 0; c < NCH[d]; c++) begin
            s_lvl = (sync >> c) & 1;
            o_lvl = (m_out[d] >> c) & 1;
            if (s_lvl == o_lvl) begin
                m_cnt[d][c] = 0;
            end else if (FLN[d] == 0 || tick[d]) begin
                m_cnt[d][c]++;
                if (FLN[d] == 0 || m_cnt[d][c] >= FLN[d]) begin
                    m_cnt[d][c] = 0;
                    nxt = nxt ^ (1 << c);
                    if (s_lvl == 1) m_rise[d] = m_rise[d] | (1 << c);
                    else            m_fall[d] = m_fall[d] | (1 << c);
                end
            end
        end
        m_out[d] = nxt;
        for (int s = 3; s > 0; s--) m_pipe[d][s] = m_pipe[d][s-1];
        m_pipe[d][0] = in_of(d);
    endtask

    task automatic compare_all();
        check("d0 data_out", 32'(out0),  m_out[0]);
        check("d0 rise",     32'(rise0), m_rise[0]);
        check("d0 fall",     32'(fall0), m_fall[0]);
        check("d1 data_out", 32'(out1),  m_out[1]);
        check("d1 rise",     32'(rise1), m_rise[1]);
        check("d1 fall",     32'(fall1), m_fall[1]);
        check("d2 data_out", 32'(out2),  m_out[2]);
        check("d2 rise",     32'(rise2), m_rise[2]);
        check("d2 fall",     32'(fall2), m_fall[2]);
    endtask

    task automatic step();
        for (int d = 0; d < 3; d++) model_edge(d);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Reset raised between edges must clear outputs without waiting for clk.
    task automatic async_reset(input int d);
        rst[d] = 1'b1;
        #1;
        model_reset(d);
        compare_all();
    endtask

    initial begin
        int nfall, rise_hits, rise_val, fall_any;
        n_chk = 0;
        n_fail = 0;
        rst  = 3'b111;
        tick = 3'b000;
        in0  = 1'b1;
        in1  = 1'b1;
        in2  = 4'b1010;
        for (int d = 0; d < 3; d++) model_reset(d);
        step();
        step();
        check("reset d2 data_out", 32'(out2), 32'hA);
        check("reset d2 pulses", 32'(rise2 | fall2), 0);
        rst = 3'b000;
        step();

        // Bypass: fall seen on the third edge after the input drops
        in0 = 1'b0;
        step(); check("t1 edge1 out", 32'(out0), 1);
        step(); check("t1 edge2 out", 32'(out0), 1);
        step(); check("t1 edge3 out", 32'(out0), 0);
                check("t1 edge3 fall", 32'(fall0), 1);
        step(); check("t1 edge4 fall", 32'(fall0), 0);

        // Two-cycle low glitch with tick every cycle is rejected
        tick[1] = 1'b1;
        in1 = 1'b0;
        step(); step();
        in1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("t2 out", 32'(out1), 1);
            check("t2 pulses", 32'(rise1 | fall1), 0);
        end

        // Sustained low with tick every 4th cycle: exactly one fall
        in1 = 1'b0;
        nfall = 0;
        for (int k = 0; k < 40; k++) begin
            tick[1] = (k % 4 == 3);
            step();
            nfall += int'(fall1);
        end
        check("t3 fall count", 32'(nfall), 1);
        check("t3 final out", 32'(out1), 0);
        in1 = 1'b1;
        tick[1] = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check("t3 restored", 32'(out1), 1);

        // Two ticks then recovery, later a full three-tick run is needed
        tick[1] = 1'b0;
        in1 = 1'b0;
        step(); step(); step();
        tick[1] = 1'b1; step(); tick[1] = 1'b0; step();
        tick[1] = 1'b1; step(); tick[1] = 1'b0;
        in1 = 1'b1;
        step(); step(); step();
        check("t4 no fall yet", 32'(out1), 1);
        in1 = 1'b0;
        step(); step(); step();
        tick[1] = 1'b1; step(); tick[1] = 1'b0; step();
        tick[1] = 1'b1; step(); tick[1] = 1'b0; step();
        check("t4 before 3rd tick", 32'(out1), 1);
        tick[1] = 1'b1; step(); tick[1] = 1'b0;
        check("t4 after 3rd tick", 32'(out1), 0);
        check("t4 fall", 32'(fall1), 1);
        in1 = 1'b1;
        tick[1] = 1'b1;
        for (int k = 0; k < 6; k++) step();

        // Reset mid-count, then a constant idle pattern never pulses
        tick[2] = 1'b1;
        in2 = 4'b0101;
        for (int k = 0; k < 5; k++) step();
        check("t5 mid-count out", 32'(out2), 32'hA);
        async_reset(2);
        check("t5 reset out", 32'(out2), 32'hA);
        check("t5 reset pulses", 32'(rise2 | fall2), 0);
        in2 = 4'b1010;
        step(); step();
        rst[2] = 1'b0;
        fall_any = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            fall_any |= int'(rise2 | fall2);
            check("t5 idle out", 32'(out2), 32'hA);
        end
        check("t5 idle pulses", 32'(fall_any), 0);

        // Channels 0 and 3 rise together, 1 and 2 stay quiet
        in2 = 4'b0010;
        for (int k = 0; k < 10; k++) step();
        in2 = 4'b1011;
        rise_hits = 0;
        rise_val = 0;
        fall_any = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (rise2 != 0) begin
                rise_hits++;
                rise_val = int'(rise2);
            end
            fall_any |= int'(fall2);
        end
        check("t6 rise events", 32'(rise_hits), 1);
        check("t6 rise lanes", 32'(rise_val), 32'h9);
        check("t6 no falls", 32'(fall_any), 0);
        check("t6 out", 32'(out2), 32'hB);

        // Random traffic, ticks and occasional resets against the model
        for (int n = 0; n < 1500; n++) begin
            tick[0] = 1'($urandom_range(0, 1));
            tick[1] = ($urandom_range(0, 2) == 0);
            tick[2] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) in0 = ~in0;
            if ($urandom_range(0, 5) == 0) in1 = ~in1;
            if ($urandom_range(0, 3) == 0) in2 = in2 ^ (4'b0001 << $urandom_range(0, 3));
            for (int d = 0; d < 3; d++) begin
                if (rst[d]) rst[d] = 1'b0;
                else if ($urandom_range(0, 199) == 0) async_reset(d);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
